mem_bus_ctrl: RTL
=================

// Module: mem_bus_ctrl
// PURPOSE
// Memory-side stage directly downstream of the datapath: takes oMemAddr/oMemData plus read/write
// strobes from the control unit and runs one valid/ready transaction on the external memory bus.
// Registers read data for the datapath's iMemData input and reports done/error to the control unit.
// Adds wait-state tolerance, misalignment checking and a bus timeout.
// PARAMETERS
// TIMEOUT_CYC  255  max cycles oBus_valid may stay high without iBus_ready before an error (1..255)
// CHECK_ALIGN  1    1: any access with iAddr[1:0]!=0 errors without a bus cycle; 0: no check
// PORTS
// iClk        in   1   system clock, rising edge
// nRst        in   1   asynchronous active-low reset
// iRd         in   1   read request from control unit (sampled only in IDLE)
// iWr         in   1   write request from control unit (sampled only in IDLE)
// iAddr       in   32  byte address (datapath oMemAddr)
// iWrData     in   32  write data (datapath oMemData)
// oRdData     out  32  last successful read data (to datapath iMemData)
// oBusy       out  1   high from the cycle after acceptance through the cycle oDone is high
// oDone       out  1   one-cycle completion pulse
// oErr        out  1   high only together with oDone: failed access
// oBus_valid  out  1   bus request valid
// oBus_we     out  1   1 = write, 0 = read; meaningful only while oBus_valid
// oBus_addr   out  32  bus address, word aligned
// oBus_wdata  out  32  bus write data
// iBus_ready  in   1   memory accepts/completes the request
// iBus_rdata  in   32  read data, valid in the cycle iBus_ready is high
// BEHAVIOUR
// - Reset: state IDLE; oRdData, oBus_addr, oBus_wdata = 0; oBusy, oDone, oErr, oBus_valid, oBus_we = 0;
//   timeout counter = 0. Async assert drops oBus_valid immediately, even mid-transaction; no oDone.
// - FSM states: IDLE, BUS, DONE, ERR.
// - IDLE: rising edge with iRd^iWr=1 and alignment OK -> latch iAddr, iWrData, iWr into the bus
//   registers; counter=0; -> BUS. iRd&iWr=1 or misaligned (CHECK_ALIGN=1) -> ERR, no bus cycle.
//   iRd=iWr=0 -> stay IDLE. Requests outside IDLE are ignored, not queued.
// - BUS: oBus_valid=1; oBus_addr/oBus_we/oBus_wdata held stable until handshake.
//   Edge with iBus_ready=1 -> handshake; on read, oRdData<=iBus_rdata; -> DONE.
//   Otherwise counter+1; when counter reaches TIMEOUT_CYC-1 without ready -> ERR (oBus_valid drops).
// - DONE: oDone=1, oErr=0 for one cycle -> IDLE. ERR: oDone=1, oErr=1 for one cycle -> IDLE;
//   oRdData unchanged on any error.
// - Latency: request at edge N -> oBus_valid from N; zero-wait memory (ready high at first edge) ->
//   oDone in cycle after edge N+1; each wait cycle adds one. Min 2 cycles request-to-oDone.
// - Counter width 8 bits, saturates (never wraps); iBus_ready after the timeout edge is ignored.
// - oRdData holds value indefinitely until next successful read; writes never alter it.
// - New request may be presented the cycle oDone is high; it is sampled on the following IDLE edge.
// - All outputs registered; no combinational path from iBus_ready/iBus_rdata to any output.
// TESTING
// - Zero-wait read: iRd pulse, iAddr=0x100, ready held 1, rdata=0xDEADBEEF -> valid 1 cycle, oDone
//   next cycle, oRdData=0xDEADBEEF, oErr=0.
// - 3-wait write: iWr, iAddr=0x204, iWrData=0x12345678, ready after 3 cycles -> addr/wdata/we=1 stable
//   4 cycles, oDone once, oRdData unchanged.
// - Misaligned read iAddr=0x102 -> oBus_valid never asserts; oDone=oErr=1 two cycles after request.
// - iRd&iWr both high -> error pulse, no bus cycle; then legal read succeeds normally.
// - Timeout: ready held 0 with TIMEOUT_CYC=4 -> oBus_valid high 4 cycles, then oDone=oErr=1; later
//   ready pulse ignored.
// - nRst low mid-BUS -> oBus_valid/oBusy drop asynchronously, no oDone; after release, IDLE, outputs 0.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: runs one valid/ready transaction per control-unit request,
// with wait-state tolerance, misalignment rejection and a saturating bus timeout.
module mem_bus_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr,
  output logic        oBus_valid,
  output logic        oBus_we,
  output logic [31:0] oBus_addr,
  output logic [31:0] oBus_wdata,
  input  logic        iBus_ready,
  input  logic [31:0] iBus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT_CYC - 1);

  state_t      state_r;
  logic [7:0]  count_r;
  logic [31:0] rd_data_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;
  logic        bus_valid_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [31:0] bus_wdata_r;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return CHECK_ALIGN && (addr[1:0] != 2'b00);
  endfunction

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_r     <= IDLE;
      count_r     <= 8'd0;
      rd_data_r   <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      bus_valid_r <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if ((iRd ^ iWr) && !is_misaligned(iAddr)) begin
            bus_addr_r  <= {iAddr[31:2], 2'b00};
            bus_wdata_r <= iWrData;
            bus_we_r    <= iWr;
            bus_valid_r <= 1'b1;
            count_r     <= 8'd0;
            busy_r      <= 1'b1;
            state_r     <= BUS;
          end else if (iRd || iWr) begin
            // Conflicting or misaligned request: fail without touching the bus.
            busy_r  <= 1'b1;
            state_r <= ERR;
          end else begin
            state_r <= IDLE;
          end
        end
        BUS: begin
          if (iBus_ready) begin
            if (!bus_we_r) begin
              rd_data_r <= iBus_rdata;
            end else begin
              rd_data_r <= rd_data_r;
            end
            bus_valid_r <= 1'b0;
            bus_we_r    <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else if (count_r == TO_LAST_C) begin
            bus_valid_r <= 1'b0;
            bus_we_r    <= 1'b0;
            done_r      <= 1'b1;
            err_r       <= 1'b1;
            state_r     <= ERR;
          end else if (count_r != 8'hFF) begin
            count_r <= count_r + 8'd1;
          end else begin
            count_r <= count_r;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        ERR: begin
          // Entered from IDLE with the pulse still pending, from BUS with it already raised.
          if (!done_r) begin
            done_r <= 1'b1;
            err_r  <= 1'b1;
          end else begin
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          bus_valid_r <= 1'b0;
          bus_we_r    <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign oRdData    = rd_data_r;
  assign oBusy      = busy_r;
  assign oDone      = done_r;
  assign oErr       = err_r;
  assign oBus_valid = bus_valid_r;
  assign oBus_we    = bus_we_r;
  assign oBus_addr  = bus_addr_r;
  assign oBus_wdata = bus_wdata_r;

endmodule
